// File: rtl/toggle_count_ctrl_pkg.sv
// Shared types for the toggle-flop counter controller.
package toggle_count_ctrl_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/toggle_count_ctrl_if.sv
// Control/status bundle between requester and counter controller.
// Optional pause input appears with TOGGLE_COUNT_CTRL_PAUSE_EN.
interface toggle_count_ctrl_if #(
  parameter int WIDTH = toggle_count_ctrl_pkg::WIDTH_DEF
);

  logic             start;
  logic             stop;
  logic             up_down;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
`ifdef TOGGLE_COUNT_CTRL_PAUSE_EN
  logic             pause;

  modport master (
    output start, stop, up_down,
    output limit, pause,
    input  q, busy, done
  );

  modport slave (
    input  start, stop, up_down,
    input  limit, pause,
    output q, busy, done
  );
`else
  modport master (
    output start, stop, up_down,
    output limit,
    input  q, busy, done
  );

  modport slave (
    input  start, stop, up_down,
    input  limit,
    output q, busy, done
  );
`endif

endinterface

// File: rtl/toggle_count_ctrl_t_ff.sv
// Single T flip-flop with asynchronous active-high clear.
module t_ff (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)  q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/toggle_count_ctrl.sv
// Start/stop up/down counter built from a T flip-flop bank.
// Define TOGGLE_COUNT_CTRL_PAUSE_EN to add a pause input.
module toggle_count_ctrl
  import toggle_count_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  toggle_count_ctrl_if.slave bus
);

  state_t           state;
  logic             dir;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] term;
  logic             busy_r;
  logic             done_r;
  logic             hold;
  logic             hit;
  logic             carry;

`ifdef TOGGLE_COUNT_CTRL_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  assign target = bus.up_down ? '0 : bus.limit;
  assign term   = dir ? lim : '0;
  assign hit    = (cnt == term);

  // Counter moves only through toggle enables; load is q^target.
  always_comb begin
    t     = '0;
    carry = 1'b1;
    unique case (1'b1)
      (state == IDLE): begin
        if (bus.start) t = cnt ^ target;
      end
      (state == RUN): begin
        if (!bus.stop && !hold && !hit) begin
          for (int i = 0; i < WIDTH; i++) begin
            t[i]  = carry;
            carry = carry & (dir ? cnt[i] : ~cnt[i]);
          end
        end
      end
      default: t = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      dir    <= 1'b0;
      lim    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            dir    <= bus.up_down;
            lim    <= bus.limit;
            state  <= RUN;
            busy_r <= 1'b1;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (!hold && hit) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    t_ff u_tff (
      .clk   (clk),
      .reset (reset),
      .t     (t[i]),
      .q     (cnt[i])
    );
  end

  assign bus.q    = cnt;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_toggle_count_ctrl.sv
// Directed bench for toggle_count_ctrl with a per-cycle scoreboard.
// Pause steps run only when TOGGLE_COUNT_CTRL_PAUSE_EN is defined.
module tb_toggle_count_ctrl;

  typedef struct packed {
    logic [3:0] q;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  obs_t sb[$];

  toggle_count_ctrl_if #(.WIDTH(4)) bus ();

  toggle_count_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input obs_t obs,
                     input obs_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got q=%0d busy=%b done=%b want q=%0d busy=%b done=%b",
             tag, obs.q, obs.busy, obs.done,
             exp.q, exp.busy, exp.done);
    end
  endtask

  function automatic obs_t now_obs();
    obs_t o;
    o.q    = bus.q;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  // Queue the expected outcome, clock once, then compare.
  task automatic step(input int q, input bit b,
                      input bit d, input string tag);
    obs_t e;
    e.q    = 4'(q);
    e.busy = b;
    e.done = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk(tag, now_obs(), sb.pop_front());
  endtask

  task automatic run_up(input int lim, input string tag);
    bus.limit   = 4'(lim);
    bus.up_down = 1'b1;
    bus.start   = 1'b1;
    step(0, 1, 0, tag);
    bus.start = 1'b0;
    for (int i = 1; i <= lim; i++) step(i, 1, 0, tag);
    step(lim, 0, 1, tag);
    step(lim, 0, 0, tag);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.up_down = 1'b0;
    bus.limit   = '0;
`ifdef TOGGLE_COUNT_CTRL_PAUSE_EN
    bus.pause   = 1'b0;
`endif
    #1;
    chk("reset", now_obs(), obs_t'(6'b0));
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, "idle");

    // Stop is meaningless in IDLE.
    bus.stop = 1'b1;
    step(0, 0, 0, "stop_idle");
    bus.stop = 1'b0;

    run_up(5, "up5");
    step(5, 0, 0, "up5_hold");

    // Down run; limit changes mid-run must not matter.
    bus.limit   = 4'd3;
    bus.up_down = 1'b0;
    bus.start   = 1'b1;
    step(3, 1, 0, "dn3");
    bus.start = 1'b0;
    bus.limit = 4'd9;
    step(2, 1, 0, "dn3");
    step(1, 1, 0, "dn3");
    step(0, 1, 0, "dn3");
    step(0, 0, 1, "dn3_done");
    step(0, 0, 0, "dn3_idle");

    // Abort at q=4; start during run ignored.
    bus.limit   = 4'd9;
    bus.up_down = 1'b1;
    bus.start   = 1'b1;
    step(0, 1, 0, "abort");
    bus.start = 1'b0;
    step(1, 1, 0, "abort");
    step(2, 1, 0, "abort");
    bus.start   = 1'b1;
    bus.up_down = 1'b0;
    step(3, 1, 0, "start_in_run");
    bus.start = 1'b0;
    step(4, 1, 0, "abort");
    bus.stop = 1'b1;
    step(4, 0, 0, "abort_stop");
    bus.stop = 1'b0;
    step(4, 0, 0, "abort_hold");
    step(4, 0, 0, "abort_hold");

    // Stop at the terminal value wins over completion.
    bus.limit   = 4'd2;
    bus.up_down = 1'b1;
    bus.start   = 1'b1;
    step(0, 1, 0, "stop_term");
    bus.start = 1'b0;
    step(1, 1, 0, "stop_term");
    step(2, 1, 0, "stop_term");
    bus.stop = 1'b1;
    step(2, 0, 0, "stop_term_x");
    bus.stop = 1'b0;
    step(2, 0, 0, "stop_term_x");

    run_up(0, "up0");
    run_up(15, "up15");
    step(15, 0, 0, "no_wrap");
    step(15, 0, 0, "no_wrap");

    // Down load from 15 to limit 0.
    bus.limit   = 4'd0;
    bus.up_down = 1'b0;
    bus.start   = 1'b1;
    step(0, 1, 0, "dn0");
    bus.start = 1'b0;
    step(0, 0, 1, "dn0_done");
    step(0, 0, 0, "dn0_idle");

    // Asynchronous reset between edges at q=6.
    bus.limit   = 4'd9;
    bus.up_down = 1'b1;
    bus.start   = 1'b1;
    step(0, 1, 0, "areset");
    bus.start = 1'b0;
    for (int i = 1; i <= 6; i++) step(i, 1, 0, "areset");
    #3;
    reset = 1'b1;
    #1;
    chk("areset_now", now_obs(), obs_t'(6'b0));
    #2;
    reset = 1'b0;
    step(0, 0, 0, "areset_idle");
    run_up(2, "after_rst");

`ifdef TOGGLE_COUNT_CTRL_PAUSE_EN
    bus.limit   = 4'd5;
    bus.up_down = 1'b1;
    bus.start   = 1'b1;
    step(0, 1, 0, "pause");
    bus.start = 1'b0;
    step(1, 1, 0, "pause");
    step(2, 1, 0, "pause");
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) step(2, 1, 0, "pause_hold");
    bus.pause = 1'b0;
    step(3, 1, 0, "pause");
    step(4, 1, 0, "pause");
    step(5, 1, 0, "pause");
    step(5, 0, 1, "pause_done");
    step(5, 0, 0, "pause_idle");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
